ram_log_dump: RTL and testbench
===============================

// Module: ram_log_dump
// PURPOSE
//  Read-side companion of the RAM logger: once the log RAM reports full, walks the captured
//  buffer from address 0 to DUMP_LEN-1 through the RAM read port (1-cycle read latency).
//  Streams each word downstream (UART tx / host link) over a valid/ready handshake.
//  Owns the RAM read address while busy; abortable at any time.
// PARAMETERS
//  NB_ADDR   10             RAM address width
//  NB_DATA   16             RAM / output data width
//  DUMP_LEN  2**NB_ADDR     words per dump, 1..2**NB_ADDR; last address read = DUMP_LEN-1
// PORTS
//  clock              in   1        system clock, all flops on posedge
//  cpu_reset          in   1        asynchronous, active-high reset
//  i_start            in   1        dump request; sampled only in IDLE
//  i_abort            in   1        cancel the dump in progress
//  i_ram_full         in   1        logger full flag; a dump starts only when high
//  o_ram_read_addr    out  NB_ADDR  RAM read address
//  i_data_from_ram    in   NB_DATA  RAM read data, valid 1 cycle after the address
//  o_data             out  NB_DATA  word to downstream
//  o_valid            out  1        o_data valid
//  i_ready            in   1        downstream accepts o_data
//  o_busy             out  1        high in any state other than IDLE
//  o_done             out  1        1-cycle pulse when the dump completes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, addr=0, o_data=0, o_valid=0, o_busy=0, o_done=0.
//  States and transitions:
//  - IDLE:  if i_start && i_ram_full -> FETCH with addr=0.
//           i_start while i_ram_full=0 is ignored.
//  - FETCH: o_ram_read_addr=addr -> WAIT (RAM registers its read).
//  - WAIT:  i_data_from_ram is valid; o_data<=i_data_from_ram, o_valid<=1 -> SEND.
//  - SEND:  o_valid=1; o_data and addr hold while i_ready=0.
//           On o_valid&&i_ready: o_valid<=0.
//             If addr==DUMP_LEN-1 -> DONE, addr<=0.
//             Otherwise addr<=addr+1 -> FETCH.
//  - DONE:  o_done=1 for exactly this cycle -> IDLE.
//  Outputs and signal rules:
//  - o_ram_read_addr = addr in every state; it is 0 in IDLE.
//  - All outputs are registered; o_done is high only in DONE.
//  - o_busy=1 in FETCH, WAIT, SEND and DONE.
//  Timing: i_start sampled at edge k -> FETCH in cycle k+1, o_valid high from cycle k+3.
//    With i_ready tied high, one word every 3 cycles; o_done in the cycle after the last handshake.
//  Address arithmetic: NB_ADDR-bit unsigned. The address never wraps mid-dump;
//    DUMP_LEN=2**NB_ADDR ends at all-ones.
//  Priority and boundary rules:
//  - i_abort (any non-IDLE state) has priority over all else: next state IDLE, o_valid<=0,
//    addr<=0, no o_done.
//  - If i_abort coincides with a SEND handshake, downstream owns that word, but the FSM
//    still goes to IDLE.
//  - i_start while busy is ignored (no restart, no queueing).
//  - i_ram_full is checked only at start; a drop mid-dump has no effect.
//  - o_valid, once high, stays high until the handshake or until abort/reset (no retraction).
// TESTING
//  1 Reset asserted mid-SEND -> o_valid/o_busy/o_data/o_ram_read_addr go to 0 without a clock
//    edge; IDLE after release.
//  2 i_ram_full=0, i_start pulse -> o_busy stays 0, o_ram_read_addr stays 0 for 20 cycles.
//  3 DUMP_LEN=8, RAM model mem[a]=3*a, i_ready=1 -> o_data sequence 0,3,...,21.
//    o_valid first seen 3 cycles after start, one word per 3 cycles, o_done 1 cycle after the
//    8th handshake.
//  4 Backpressure: i_ready=0 for 5 cycles on word 2 -> o_data holds 6, o_ram_read_addr holds 2.
//    Word stream has no gaps and no duplicates.
//  5 i_abort in WAIT of word 4 -> IDLE next cycle, no o_done.
//    A fresh i_start then emits from address 0 (data 0).
//  6 Default DUMP_LEN=1024, i_start re-pulsed while busy -> start is ignored.
//    Last address 1023 -> o_done, addr returns to 0, no reread of address 0.

Source files
------------

// File: rtl/ram_log_dump_if.sv
// Bundle of the dump engine's control, RAM read port and downstream stream signals.
// The master modport is the dump engine; slave is the surrounding system.
interface ram_log_dump_if #(
    parameter int NB_ADDR = 10,
    parameter int NB_DATA = 16
);
    logic               i_start;
    logic               i_abort;
    logic               i_ram_full;
    logic [NB_ADDR-1:0] o_ram_read_addr;
    logic [NB_DATA-1:0] i_data_from_ram;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_busy;
    logic               o_done;

    modport master (
        input  i_start, i_abort, i_ram_full, i_data_from_ram, i_ready,
        output o_ram_read_addr, o_data, o_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_abort, i_ram_full, i_data_from_ram, i_ready,
        input  o_ram_read_addr, o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/ram_log_dump.sv
// Dumps a full log RAM word by word (addresses 0..DUMP_LEN-1) onto a valid/ready stream.
// Each word takes FETCH (address out), WAIT (RAM latency) and SEND (handshake).
module ram_log_dump #(
    parameter int NB_ADDR  = 10,
    parameter int NB_DATA  = 16,
    parameter int DUMP_LEN = 2**NB_ADDR
) (
    input  logic           clock,
    input  logic           cpu_reset,
    ram_log_dump_if.master bus
);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DUMP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;
    logic [NB_DATA-1:0] data_q,  data_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start && bus.i_ram_full) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = bus.i_data_from_ram;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && bus.i_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        addr_d  = '0;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + NB_ADDR'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
        end

        // Status outputs are registered from the next state so they align with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_ram_read_addr = addr_q;
    assign bus.o_data          = data_q;
    assign bus.o_valid         = valid_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
endmodule

// File: tb/tb_ram_log_dump.sv
// Scoreboard bench: a short-dump instance (8 words) and a full-size instance (1024 words),
// each fed by a behavioural registered-read RAM and checked by an independent monitor.
`timescale 1ns/1ps
module tb_ram_log_dump;
    localparam int NB_ADDR = 10;
    localparam int NB_DATA = 16;
    localparam int LEN_S   = 8;
    localparam int LEN_L   = 1024;

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [NB_DATA-1:0] data;
    } beat_t;

    logic clock = 1'b0;
    logic cpu_reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_log_dump_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus_s ();
    ram_log_dump_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus_l ();

    ram_log_dump #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .DUMP_LEN(LEN_S)) dut_s (
        .clock     (clock),
        .cpu_reset (cpu_reset),
        .bus       (bus_s.master)
    );

    ram_log_dump #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) dut_l (
        .clock     (clock),
        .cpu_reset (cpu_reset),
        .bus       (bus_l.master)
    );

    // Behavioural log RAMs with one cycle of read latency
    logic [NB_DATA-1:0] mem_s [LEN_L];
    logic [NB_DATA-1:0] mem_l [LEN_L];
    always @(posedge clock) bus_s.i_data_from_ram <= mem_s[bus_s.o_ram_read_addr];
    always @(posedge clock) bus_l.i_data_from_ram <= mem_l[bus_l.o_ram_read_addr];

    beat_t exp_s[$];
    beat_t exp_l[$];
    int    hs_s[$];
    int    done_due_s = -1;
    int    done_due_l = -1;
    int    first_valid_s = -1;
    int    done_cnt_l = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit idle_s();
        return (exp_s.size() == 0) && (done_due_s < 0);
    endfunction

    // Monitors sample mid-cycle; a valid&&ready seen here is taken at the next rising edge
    always @(negedge clock) begin
        beat_t b;
        if (!cpu_reset) begin
            if (bus_s.o_valid && first_valid_s < 0) first_valid_s = cyc;
            if (bus_s.o_valid && bus_s.i_ready) begin
                hs_s.push_back(cyc);
                check("s_word_expected", int'(exp_s.size() != 0), 1);
                if (exp_s.size() != 0) begin
                    b = exp_s.pop_front();
                    check("s_addr", int'(bus_s.o_ram_read_addr), int'(b.addr));
                    check("s_data", int'(bus_s.o_data), int'(b.data));
                    if (exp_s.size() == 0) done_due_s = cyc + 1;
                end
            end
            if (bus_s.o_done || done_due_s == cyc) begin
                check("s_done_pulse", int'(bus_s.o_done), int'(done_due_s == cyc));
                done_due_s = -1;
            end
        end
    end

    always @(negedge clock) begin
        beat_t b;
        if (!cpu_reset) begin
            if (bus_l.o_valid && bus_l.i_ready) begin
                check("l_word_expected", int'(exp_l.size() != 0), 1);
                if (exp_l.size() != 0) begin
                    b = exp_l.pop_front();
                    check("l_addr", int'(bus_l.o_ram_read_addr), int'(b.addr));
                    check("l_data", int'(bus_l.o_data), int'(b.data));
                    if (exp_l.size() == 0) done_due_l = cyc + 1;
                end
            end
            if (bus_l.o_done || done_due_l == cyc) begin
                check("l_done_pulse", int'(bus_l.o_done), int'(done_due_l == cyc));
                if (bus_l.o_done) done_cnt_l++;
                done_due_l = -1;
            end
        end
    end

    // Pulses i_start for one edge; a dump is expected only if idle and the RAM is full
    task automatic start_s(output int edge_cyc);
        bus_s.i_start = 1'b1;
        if (idle_s() && bus_s.i_ram_full)
            for (int a = 0; a < LEN_S; a++) exp_s.push_back('{addr: NB_ADDR'(a), data: mem_s[a]});
        @(posedge clock); #1;
        bus_s.i_start = 1'b0;
        edge_cyc = cyc;
    endtask

    task automatic wait_idle_s(input int budget);
        int n = 0;
        while ((bus_s.o_busy || !idle_s()) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check("s_dump_finished", int'(n < budget), 1);
        exp_s.delete();
        done_due_s = -1;
    endtask

    task automatic wait_addr_s(input int a);
        int n = 0;
        while (int'(bus_s.o_ram_read_addr) != a && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("s_reach_addr", int'(bus_s.o_ram_read_addr), a);
    endtask

    task automatic wait_valid_s();
        int n = 0;
        while (!bus_s.o_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("s_valid_up", int'(bus_s.o_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        bus_s.i_start = 1'b0; bus_s.i_abort = 1'b0; bus_s.i_ram_full = 1'b0; bus_s.i_ready = 1'b1;
        bus_l.i_start = 1'b0; bus_l.i_abort = 1'b0; bus_l.i_ram_full = 1'b0; bus_l.i_ready = 1'b1;
        for (int a = 0; a < LEN_L; a++) begin
            mem_s[a] = NB_DATA'(3 * a);
            mem_l[a] = NB_DATA'($urandom);
        end

        // Reset state
        #12;
        check("rst_s_valid", int'(bus_s.o_valid), 0);
        check("rst_s_busy",  int'(bus_s.o_busy), 0);
        check("rst_s_done",  int'(bus_s.o_done), 0);
        check("rst_s_data",  int'(bus_s.o_data), 0);
        check("rst_s_addr",  int'(bus_s.o_ram_read_addr), 0);
        check("rst_l_busy",  int'(bus_l.o_busy), 0);
        @(posedge clock); #1;
        cpu_reset = 1'b0;
        @(posedge clock); #1;

        // Start while the RAM is not full is ignored
        start_s(e);
        for (int i = 0; i < 20; i++) begin
            check("notfull_busy", int'(bus_s.o_busy), 0);
            check("notfull_addr", int'(bus_s.o_ram_read_addr), 0);
            @(posedge clock); #1;
        end

        // Full 8-word dump with i_ready high: 0,3,...,21, one word every 3 cycles
        bus_s.i_ram_full = 1'b1;
        first_valid_s = -1;
        hs_s.delete();
        start_s(e);
        wait_idle_s(100);
        check("first_valid_latency", first_valid_s - e, 2);
        check("handshake_count", hs_s.size(), LEN_S);
        for (int i = 1; i < hs_s.size(); i++) check("word_spacing", hs_s[i] - hs_s[i-1], 3);

        // Backpressure on word 2: data and address hold
        start_s(e);
        wait_addr_s(2);
        bus_s.i_ready = 1'b0;
        wait_valid_s();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_data",  int'(bus_s.o_data), 6);
            check("bp_addr",  int'(bus_s.o_ram_read_addr), 2);
            check("bp_valid", int'(bus_s.o_valid), 1);
        end
        @(posedge clock); #1;
        bus_s.i_ready = 1'b1;
        wait_idle_s(100);

        // Abort in WAIT of word 4, then a fresh dump from address 0
        start_s(e);
        wait_addr_s(4);
        @(posedge clock); #1;
        bus_s.i_abort = 1'b1;
        @(posedge clock); #1;
        bus_s.i_abort = 1'b0;
        exp_s.delete();
        done_due_s = -1;
        check("abort_busy",  int'(bus_s.o_busy), 0);
        check("abort_valid", int'(bus_s.o_valid), 0);
        check("abort_addr",  int'(bus_s.o_ram_read_addr), 0);
        repeat (5) @(posedge clock);
        #1;
        start_s(e);
        wait_idle_s(100);

        // Asynchronous reset in the middle of SEND
        for (int a = 0; a < LEN_S; a++) mem_s[a] = NB_DATA'($urandom) | NB_DATA'(1);
        start_s(e);
        wait_addr_s(3);
        bus_s.i_ready = 1'b0;
        wait_valid_s();
        #2;
        cpu_reset = 1'b1;
        #1;
        check("arst_valid", int'(bus_s.o_valid), 0);
        check("arst_busy",  int'(bus_s.o_busy), 0);
        check("arst_data",  int'(bus_s.o_data), 0);
        check("arst_addr",  int'(bus_s.o_ram_read_addr), 0);
        exp_s.delete();
        done_due_s = -1;
        @(posedge clock); #1;
        cpu_reset = 1'b0;
        bus_s.i_ready = 1'b1;
        @(posedge clock); #1;
        check("post_rst_busy",  int'(bus_s.o_busy), 0);
        check("post_rst_valid", int'(bus_s.o_valid), 0);

        // Randomized dumps: random data, random backpressure, ram_full noise, occasional abort
        for (int r = 0; r < 12; r++) begin
            int abort_at;
            for (int a = 0; a < LEN_S; a++) mem_s[a] = NB_DATA'($urandom);
            bus_s.i_ram_full = 1'b1;
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1;
            start_s(e);
            n = 0;
            while ((bus_s.o_busy || !idle_s()) && n < 400) begin
                bus_s.i_ready    = ($urandom_range(0, 3) != 0);
                bus_s.i_ram_full = 1'($urandom_range(0, 1));
                bus_s.i_abort    = (n == abort_at);
                @(posedge clock); #1;
                if (bus_s.i_abort) begin
                    exp_s.delete();
                    done_due_s = -1;
                    bus_s.i_abort = 1'b0;
                end
                n++;
            end
            bus_s.i_abort = 1'b0;
            bus_s.i_ready = 1'b1;
            check("rand_dump_finished", int'(n < 400), 1);
            exp_s.delete();
            done_due_s = -1;
        end

        // Full-size dump; a second start while busy must be ignored
        bus_l.i_ram_full = 1'b1;
        bus_l.i_start = 1'b1;
        for (int a = 0; a < LEN_L; a++) exp_l.push_back('{addr: NB_ADDR'(a), data: mem_l[a]});
        @(posedge clock); #1;
        bus_l.i_start = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        bus_l.i_start = 1'b1;
        @(posedge clock); #1;
        bus_l.i_start = 1'b0;
        n = 0;
        while ((bus_l.o_busy || exp_l.size() != 0 || done_due_l >= 0) && n < 4000) begin
            @(posedge clock); #1;
            n++;
        end
        check("l_dump_finished", int'(n < 4000), 1);
        check("l_done_count", done_cnt_l, 1);
        check("l_words_left", exp_l.size(), 0);
        for (int i = 0; i < 10; i++) begin
            check("l_after_valid", int'(bus_l.o_valid), 0);
            check("l_after_addr",  int'(bus_l.o_ram_read_addr), 0);
            check("l_after_busy",  int'(bus_l.o_busy), 0);
            @(posedge clock); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
